// File: rtl/mem_arbiter_if.sv
// Handshake bundle shared by the arbiter, its two requesters and the memory.
// slave: arbiter view; master: requester/memory (environment) view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  mem_req;
  logic                  mem_wr;
  logic [1:0]            mem_size;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size,
    input  data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size,
    output mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size,
    output data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size,
    input  mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// IF/data arbiter for one shared memory port, one transaction in flight.
// Define MEM_ARB_STATS_EN to get per-requester grant counters.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave bus,
  output logic [31:0] inst_grant_cnt,
  output logic [31:0] data_grant_cnt
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e            state_q;
  logic              own_q;
  logic [CW-1:0]     starve_q;
  logic [CW-1:0]     starve_d;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [SW-1:0]     wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mreq_q;
  logic              iok_q;
  logic              dok_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              pick_i;
  logic              pick_d;

  // Grant decision in IDLE plus starvation counter update.
  always_comb begin
    pick_i   = 1'b0;
    pick_d   = 1'b0;
    starve_d = starve_q;
    if (state_q == IDLE) begin
      pick_i = bus.inst_req &&
               (!bus.data_req || starve_q == SMAX);
      pick_d = bus.data_req && !pick_i;
    end
    if (pick_d && bus.inst_req) begin
      if (starve_q != SMAX)
        starve_d = starve_q + CW'(1);
    end else if (pick_i || pick_d) begin
      starve_d = '0;
    end
  end

  // Transaction FSM: latch request, drive memory, return response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      own_q    <= 1'b1;
      starve_q <= '0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      wstrb_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mreq_q   <= 1'b0;
      iok_q    <= 1'b0;
      dok_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (pick_i || pick_d) begin
            state_q <= REQ;
            mreq_q  <= 1'b1;
            own_q   <= pick_i;
            if (pick_i) begin
              wr_q    <= 1'b0;
              size_q  <= 2'd2;
              wstrb_q <= '0;
              addr_q  <= bus.inst_addr;
              wdata_q <= '0;
            end else begin
              wr_q    <= bus.data_wr;
              size_q  <= bus.data_size;
              wstrb_q <= bus.data_wstrb;
              addr_q  <= bus.data_addr;
              wdata_q <= bus.data_wdata;
            end
          end
        end
        REQ: begin
          if (bus.mem_addr_ok) begin
            state_q <= WAIT;
            mreq_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.mem_data_ok) begin
            state_q <= RESP;
            if (own_q) begin
              iok_q    <= 1'b1;
              irdata_q <= wr_q ? '0 : bus.mem_rdata;
            end else begin
              dok_q    <= 1'b1;
              drdata_q <= wr_q ? '0 : bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          iok_q   <= 1'b0;
          dok_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inst_addr_ok = pick_i;
  assign bus.data_addr_ok = pick_d;
  assign bus.inst_data_ok = iok_q;
  assign bus.data_data_ok = dok_q;
  assign bus.inst_rdata   = irdata_q;
  assign bus.data_rdata   = drdata_q;
  assign bus.mem_req      = mreq_q;
  assign bus.mem_wr       = wr_q;
  assign bus.mem_size     = size_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icnt_q;
  logic [31:0] dcnt_q;

  // Count grants issued from IDLE; wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (pick_i) icnt_q <= icnt_q + 32'd1;
      if (pick_d) dcnt_q <= dcnt_q + 32'd1;
    end
  end

  assign inst_grant_cnt = icnt_q;
  assign data_grant_cnt = dcnt_q;
`else
  assign inst_grant_cnt = '0;
  assign data_grant_cnt = '0;
`endif
endmodule
